// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t     - arbiter FSM state (ST_IDLE / ST_BUSY)
//   N_REQ       - number of requesting agents
//   idx_to_sel  - owner index to datapath mux select (select is the inverted index)
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The datapath mux is wired in reverse agent order, so select 2'b00 picks
    // agent 3 and 2'b11 picks agent 0.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating first-set picker over four request lines.
// Latency: combinational, zero cycles.
// Backpressure: none; found/idx reflect the inputs every cycle.
//
// Ports:
//   req[3:0]         request vector, bit i for agent i
//   start_idx[1:0]   first agent examined; scan continues upward modulo 4
//   exclude_en       when high, agent exclude_idx is never chosen
//   exclude_idx[1:0] agent to skip (the current owner on a hand-over)
//   found            some eligible request exists
//   idx[1:0]         chosen agent, valid when found is high
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start_idx,
    input  logic       exclude_en,
    input  logic [1:0] exclude_idx,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start_idx;
        cand  = start_idx;
        // First hit wins; later candidates are ignored once found is set.
        for (int k = 0; k < N_REQ; k++) begin
            cand = start_idx + 2'(k);
            if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter sharing one 1-bit 4:1 select mux among four agents.
// Latency: req -> grant/S one cycle; D[owner] -> out/out_valid one cycle after a grant-held cycle.
// Backpressure: owner keeps the grant until it drops req (or hits the burst limit when enabled).
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   req[3:0]        per-agent request
//   D[3:0]          per-agent data bit
//   grant[3:0]      registered one-hot grant, zero when idle
//   S[1:0]          registered mux select, ~owner_idx; holds its value while idle
//   out             registered D[owner], updated on every grant-held cycle
//   out_valid       qualifies out; high the cycle after a grant-held cycle
//   busy            high while the arbiter has an owner
//
// Build option: define ARB_BURST_LIMIT_EN to force rotation after MAX_BURST
// consecutive grant cycles when another agent is waiting.
module rr_mux_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] D,
    output logic [3:0] grant,
    output logic [1:0] S,
    output logic       out,
    output logic       out_valid,
    output logic       busy
);

    // The burst counter must be able to hold MAX_BURST itself.
    if ((2 ** CNT_W) <= MAX_BURST) begin : g_bad_cfg
        $error("rr_mux_arbiter4: CNT_W too narrow for MAX_BURST");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last_idx;
    logic [1:0] last_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] s_nxt;
    logic       load;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic       burst_hit;
    logic       hand_over;

    // One picker serves both states: in IDLE it scans all four agents starting
    // after last_idx (which wraps back to last_idx itself); in BUSY last_idx is
    // the owner and is excluded so a release hands over to someone else.
    rr_pick4 u_pick (
        .req         (req),
        .start_idx   (last_idx + 2'd1),
        .exclude_en  (state == ST_BUSY),
        .exclude_idx (last_idx),
        .found       (pick_found),
        .idx         (pick_idx)
    );

`ifdef ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] burst_cnt;

    assign burst_hit = (burst_cnt == CNT_W'(MAX_BURST));

    // Counts consecutive grant cycles of the current owner. A fresh grant
    // starts at 1; holding saturates at MAX_BURST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (load) begin
            burst_cnt <= CNT_W'(1);
        end else if (state_nxt == ST_IDLE) begin
            burst_cnt <= '0;
        end else if ((state == ST_BUSY) && !burst_hit) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    // Owner gives up the slot when it drops req, or when its burst is spent.
    // A spent burst with nobody else waiting finds no candidate and the owner
    // simply keeps the grant.
    assign hand_over = !req[last_idx] || burst_hit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            last_idx  <= 2'd3;
            grant     <= 4'b0000;
            S         <= 2'b11;
        end else begin
            state     <= state_nxt;
            last_idx  <= last_nxt;
            grant     <= grant_nxt;
            S         <= s_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        last_nxt  = last_idx;
        grant_nxt = grant;
        s_nxt     = S;
        load      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_BUSY;
                    load      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (hand_over && pick_found) begin
                    // Direct hand-over, no idle bubble.
                    load = 1'b1;
                end else if (!req[last_idx]) begin
                    // Released with nobody waiting; S keeps the last owner.
                    state_nxt = ST_IDLE;
                    grant_nxt = 4'b0000;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 4'b0000;
            end
        endcase

        if (load) begin
            grant_nxt = 4'b0001 << pick_idx;
            s_nxt     = idx_to_sel(pick_idx);
            last_nxt  = pick_idx;
        end
    end

    // Output logic
    always_comb begin
        busy = (state == ST_BUSY);
    end

    // Datapath capture: grant is one-hot at last_idx whenever it is non-zero,
    // so last_idx selects the owner's data bit directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else if (grant != 4'b0000) begin
            out       <= D[last_idx];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Self-checking bench for rr_mux_arbiter4.
// Latency: expectations are queued one per clock edge and checked 1 time unit after it.
// Backpressure: n/a.
module tb_rr_mux_arbiter4;

    localparam int MB = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] D;
    logic [3:0] grant;
    logic [1:0] S;
    logic       out;
    logic       out_valid;
    logic       busy;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       ov;
        logic       o;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] pg;        // expected grant before the coming edge
    logic       exp_out;   // expected held value of out
    int         n_checks;
    int         n_pass;

    rr_mux_arbiter4 #(.MAX_BURST(MB), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .D         (D),
        .grant     (grant),
        .S         (S),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle: randomise D, queue the expected post-edge outputs,
    // then advance past the edge.
    task automatic cyc(input logic [3:0] g, input logic [1:0] s, input logic b);
        exp_t e;
        D    = 4'($urandom);
        e.g  = g;
        e.s  = s;
        e.b  = b;
        e.ov = (pg != 4'b0000);
        if (pg != 4'b0000) exp_out = D[oh2idx(pg)];
        e.o  = exp_out;
        exp_q.push_back(e);
        pg = g;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: pop one expectation per edge and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (grant !== e.g || S !== e.s || busy !== e.b || out_valid !== e.ov || out !== e.o) begin
                $display("FAIL cycle@%0t: got grant=%b S=%b busy=%b out_valid=%b out=%b, required grant=%b S=%b busy=%b out_valid=%b out=%b",
                         $time, grant, S, busy, out_valid, out, e.g, e.s, e.b, e.ov, e.o);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic test_reset;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0000 || S !== 2'b11 || out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_state: got grant=%b S=%b out=%b out_valid=%b busy=%b, required 0000 11 0 0 0",
                     grant, S, out, out_valid, busy);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #2;
        reset   = 1'b0;
        pg      = 4'b0000;
        exp_out = 1'b0;
    endtask

    task automatic test_rotation;
        req = 4'b1111; cyc(4'b0001, 2'b11, 1'b1);
        req = 4'b1110; cyc(4'b0010, 2'b10, 1'b1);
        req = 4'b1100; cyc(4'b0100, 2'b01, 1'b1);
        req = 4'b1000; cyc(4'b1000, 2'b00, 1'b1);
        req = 4'b0000; cyc(4'b0000, 2'b00, 1'b0);
        cyc(4'b0000, 2'b00, 1'b0);
    endtask

    task automatic test_hold;
        req = 4'b0100;
        for (int i = 0; i < 20; i++) cyc(4'b0100, 2'b01, 1'b1);
        req = 4'b0000;
        cyc(4'b0000, 2'b01, 1'b0);
        cyc(4'b0000, 2'b01, 1'b0);
    endtask

    task automatic test_release_idle;
        req = 4'b0010; cyc(4'b0010, 2'b10, 1'b1);
        cyc(4'b0010, 2'b10, 1'b1);
        req = 4'b0000; cyc(4'b0000, 2'b10, 1'b0);
        req = 4'b0011; cyc(4'b0001, 2'b11, 1'b1);
    endtask

    task automatic test_reacquire;
        req = 4'b0010; cyc(4'b0010, 2'b10, 1'b1);
        req = 4'b0011; cyc(4'b0010, 2'b10, 1'b1);
        req = 4'b0001; cyc(4'b0001, 2'b11, 1'b1);
        req = 4'b1000; cyc(4'b1000, 2'b00, 1'b1);
        cyc(4'b1000, 2'b00, 1'b1);
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || S !== 2'b11 || out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL async_reset: got grant=%b S=%b out=%b out_valid=%b busy=%b, required 0000 11 0 0 0",
                     grant, S, out, out_valid, busy);
        end else begin
            n_pass++;
        end
        @(posedge clk);
        #2;
        req     = 4'b1001;
        reset   = 1'b0;
        pg      = 4'b0000;
        exp_out = 1'b0;
        cyc(4'b0001, 2'b11, 1'b1);
    endtask

    task automatic test_burst;
        logic [1:0] owner;
        int         held;
        owner = 2'd0;
        held  = 1;
        req   = 4'b0011;
        for (int i = 0; i < 40; i++) begin
`ifdef ARB_BURST_LIMIT_EN
            if (held == MB) begin
                owner = owner ^ 2'd1;
                held  = 1;
            end else begin
                held++;
            end
`endif
            cyc(4'b0001 << owner, ~owner, 1'b1);
        end
        req = 4'b0000;
        cyc(4'b0000, ~owner, 1'b0);
        cyc(4'b0000, ~owner, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        D        = 4'b0000;
        pg       = 4'b0000;
        exp_out  = 1'b0;
        n_checks = 0;
        n_pass   = 0;

        test_reset;
        test_rotation;
        test_hold;
        test_release_idle;
        test_reacquire;
        test_reset_mid;
        test_burst;

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter4.md
Name: rr_mux_arbiter4

Overview:
- Round-robin arbiter that shares one 1-bit 4:1 select mux among four requesters.
- Sits between four requesting agents and the mux datapath.
- Grants one owner at a time and drives the mux select and a registered copy of the selected bit.
- Owners hold the grant until they drop their request; an optional burst limit forces rotation.

Parameters:
- MAX_BURST, 8, maximum consecutive grant cycles per owner while others wait. Only used with ARB_BURST_LIMIT_EN.
- CNT_W, 4, burst counter width. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per agent; req[i] for agent i.
- D  input  4  data bit per agent; D[i] belongs to agent i.
- grant  output  4  one-hot grant, registered; all zero when idle.
- S  output  2  mux select to datapath. Encoding: 2'b00 picks agent 3, 2'b01 agent 2, 2'b10 agent 1, 2'b11 agent 0; i.e. S = ~owner_idx.
- out  output  1  registered bit from the current owner: D[owner] sampled each cycle the grant is held.
- out_valid  output  1  high the cycle after any grant-held cycle, qualifying out.
- busy  output  1  high in state BUSY.

Behaviour:
- Reset (async, immediate):
  - grant=4'b0000, S=2'b11, out=0, out_valid=0, busy=0.
  - state=IDLE, last_idx=3 so agent 0 has top priority first, burst_cnt=0.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0, choose the first asserted req[i] scanning last_idx+1, +2, +3, +4 (mod 4).
  - At the next edge: go to BUSY, grant one-hot at i, S=~i, last_idx=i, burst_cnt=1.
  - Latency: req sampled high -> grant high on the following edge (1 cycle).
- BUSY, req[owner]=1:
  - Hold grant; burst_cnt increments, saturating at MAX_BURST.
- BUSY, req[owner]=0 in cycle n:
  - At edge n+1, pick the next requester scanning from owner+1, excluding the owner.
  - If found: grant moves directly, with no idle cycle, and burst_cnt=1.
  - If none: go to IDLE, grant=0, S keeps its last value.
- Same agent re-requesting: it must drop req for at least one sampled cycle. Dropping for one cycle loses the grant if others are waiting.
- Simultaneous events: owner drops while several others request -> rotation order decides. A new req arriving in the same cycle as a release is eligible.
- out and out_valid:
  - out <= D[owner] on every edge where grant!=0 before the edge.
  - out_valid mirrors that condition; otherwise out_valid=0 and out holds its value.
- grant is always one-hot or zero, never multi-hot.
- Reset asserted mid-grant: everything clears asynchronously. Arbitration resumes with agent 0 priority after reset deasserts.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- Defined: in BUSY, if burst_cnt==MAX_BURST and any other req is high, rotate at the next edge as if the owner had released, even if req[owner] is still 1. The owner re-enters rotation normally. If no other request is pending, the owner keeps the grant and burst_cnt stays saturated.
- Undefined: no burst counter logic; the owner holds the grant indefinitely.

Decomposition:
- Package/header arb_pkg: state encodings ST_IDLE=1'b0, ST_BUSY=1'b1; constant N_REQ=4; function idx_to_sel(idx)=~idx.
- Sub-module rr_pick4 (combinational): inputs req[3:0], start_idx[1:0], exclude_en, exclude_idx; outputs found, idx[1:0]. Used in both IDLE and BUSY.

Test Plan:
- Reset, then req=4'b1111 -> one cycle later grant=0001, S=11.
  - Drop req[0] -> next edge grant=0010, S=10.
  - Then 0100, S=01; then 1000, S=00.
- req=4'b0100 held 20 cycles with D[2] toggling -> grant=0100 all 20 cycles; out follows D[2] one cycle late; out_valid=1 throughout.
- Owner agent 1 drops req, no others pending -> next edge grant=0000, busy=0, out_valid=0 one cycle later.
  - Then req=4'b0011 -> grant=0001, because rotation starts after last_idx=1.
- Assert reset while grant=1000 -> grant=0000, S=11 immediately (before clock).
  - Release reset with req=1001 -> grant=0001.
- With ARB_BURST_LIMIT_EN, MAX_BURST=8: req=0011 held constant -> grant alternates 0001/0010, each held 8 cycles.
  - Without the macro: grant=0001 forever.
